// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory sequencer.
// The top-level file mem_access_ctrl.sv has an optional misaligned-access trap, enabled by defining MEM_MISALIGN_TRAP_EN.
package mem_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned WAIT_W = 8;

    // Decoder MemNum encodings
    typedef enum logic [1:0] {
        MN_NONE = 2'b00,
        MN_BYTE = 2'b01,
        MN_HALF = 2'b10,
        MN_WORD = 2'b11
    } mem_num_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    // Big-endian lane positions: byte offset 0 sits in bits [31:24]
    localparam logic [4:0] LANE0_LSB   = 5'd24;
    localparam logic [4:0] LANE1_LSB   = 5'd16;
    localparam logic [4:0] LANE2_LSB   = 5'd8;
    localparam logic [4:0] LANE3_LSB   = 5'd0;
    localparam logic [4:0] HALF_HI_LSB = 5'd16;
    localparam logic [4:0] HALF_LO_LSB = 5'd0;

    // Force the byte offset onto the natural boundary of the access size
    function automatic logic [OFF_W-1:0] align_off(input mem_num_t num, input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] res;
        case (num)
            MN_HALF: res = {off[1], 1'b0};
            MN_WORD: res = 2'b00;
            default: res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: sub-word load extraction/extension and RMW store merge.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  mem_num_t            mem_num,
    input  logic                zero_ext,
    input  logic [OFF_W-1:0]    offset,
    input  logic [WORD_W-1:0]   rword,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   load_data,
    output logic [WORD_W-1:0]   merge_word
);

    logic [4:0]        byte_lsb;
    logic [4:0]        half_lsb;
    logic [BYTE_W-1:0] sel_byte;
    logic [HALF_W-1:0] sel_half;

    // Select the addressed lane, then extend it or splice the store data into it
    always_comb begin
        byte_lsb   = LANE0_LSB;
        half_lsb   = HALF_HI_LSB;
        load_data  = '0;
        merge_word = rword;

        case (offset)
            2'd0:    byte_lsb = LANE0_LSB;
            2'd1:    byte_lsb = LANE1_LSB;
            2'd2:    byte_lsb = LANE2_LSB;
            default: byte_lsb = LANE3_LSB;
        endcase
        half_lsb = offset[1] ? HALF_LO_LSB : HALF_HI_LSB;

        sel_byte = rword[byte_lsb +: BYTE_W];
        sel_half = rword[half_lsb +: HALF_W];

        case (mem_num)
            MN_BYTE: begin
                load_data = zero_ext ? {{(WORD_W-BYTE_W){1'b0}}, sel_byte}
                                     : {{(WORD_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
                merge_word[byte_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            MN_HALF: begin
                load_data = zero_ext ? {{(WORD_W-HALF_W){1'b0}}, sel_half}
                                     : {{(WORD_W-HALF_W){sel_half[HALF_W-1]}}, sel_half};
                merge_word[half_lsb +: HALF_W] = wdata[HALF_W-1:0];
            end
            MN_WORD: begin
                load_data  = rword;
                merge_word = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory sequencer: word-only req/ack port, sub-word loads, RMW sub-word stores,
// misalignment handling and ack timeout. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    input  logic [1:0]          MemNum_i,
    input  logic                UnSigned_i,
    input  logic [WORD_W-1:0]   addr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [WORD_W-1:0]   rdata_o,
    output logic                stall_o,
    output logic                done_o,
    output logic                err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [WORD_W-1:0]   mem_wdata_o,
    input  logic [WORD_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i
);

    state_t              state;
    state_t              state_nxt;
    mem_num_t            mem_num;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic [WORD_W-1:0]   rdata_nxt;
    logic [WORD_W-1:0]   wdata_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                err_nxt;
    logic                accept;
    logic                ack;
    logic                timeout;
    logic                misaligned;
    logic [OFF_W-1:0]    eff_off;
    logic [WORD_W-1:0]   load_data;
    logic [WORD_W-1:0]   merge_word;
    logic                unused_addr;

    assign mem_num     = mem_num_t'(MemNum_i);
    assign accept      = (state == IDLE) && req_i && (MemRead_i || MemWrite_i);
    assign ack         = mem_ack_i && mem_req_o;
    assign timeout     = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign eff_off     = align_off(mem_num, addr_i[OFF_W-1:0]);
    assign unused_addr = ^addr_i[WORD_W-1:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((mem_num == MN_HALF) && addr_i[0]) ||
                        ((mem_num == MN_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Pipeline freeze: from the cycle a request is presented until the access completes
    assign stall_o = accept || (state == RD) || (state == WR);

    mem_lane_align u_lane_align (
        .mem_num    (mem_num),
        .zero_ext   (UnSigned_i),
        .offset     (eff_off),
        .rword      (mem_rdata_i),
        .wdata      (wdata_i),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision; stores always win over loads
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((mem_num == MN_NONE) || misaligned)      state_nxt = DONE;
                    else if (MemWrite_i && (mem_num == MN_WORD)) state_nxt = WR;
                    else                                         state_nxt = RD;
                end
            end
            RD: begin
                if (ack)          state_nxt = MemWrite_i ? WR : DONE;
                else if (timeout) state_nxt = DONE;
            end
            WR: begin
                if (ack || timeout) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered data-path outputs and wait counter
    always_comb begin
        err_nxt      = 1'b0;
        rdata_nxt    = rdata_o;
        wdata_nxt    = mem_wdata_o;
        addr_nxt     = mem_addr_o;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    addr_nxt     = addr_i[ADDR_W+1:2];
                    wait_cnt_nxt = '0;
                    if ((mem_num == MN_NONE) || misaligned) begin
                        err_nxt   = misaligned;
                        rdata_nxt = '0;
                    end else if (MemWrite_i && (mem_num == MN_WORD)) begin
                        wdata_nxt = wdata_i;
                    end
                end
            end
            RD: begin
                if (ack) begin
                    if (MemWrite_i) begin
                        wdata_nxt    = merge_word;
                        wait_cnt_nxt = '0;
                    end else begin
                        rdata_nxt = load_data;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            WR: begin
                if (!ack) begin
                    if (timeout) err_nxt = 1'b1;
                    else         wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wait_cnt    <= '0;
        end else begin
            mem_req_o   <= (state_nxt == RD) || (state_nxt == WR);
            mem_we_o    <= (state_nxt == WR);
            done_o      <= (state_nxt == DONE);
            err_o       <= err_nxt;
            rdata_o     <= rdata_nxt;
            mem_addr_o  <= addr_nxt;
            mem_wdata_o <= wdata_nxt;
            wait_cnt    <= wait_cnt_nxt;
        end
    end

endmodule
